// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited write-port arbiter in front of the async FIFO write side.
// Optional statistics counters are built only when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                  w_clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  w_full,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      fifo_w_data,
  output logic                  fifo_w_en,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           word_cnt
);

  localparam int IDXW = $clog2(NREQ);
  localparam int BCW  = $clog2(BURST_MAX) + 1;
  localparam logic [BCW-1:0]  BCNT_LAST = BCW'(BURST_MAX - 1);
  localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDXW-1:0] gidx, gidx_nxt;
  logic [IDXW-1:0] last, last_nxt;
  logic [BCW-1:0]  bcnt, bcnt_nxt;
  logic [IDXW-1:0] cand, pick;
  logic            pick_vld;
  logic            accept;

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDXW'((int'(last) + off) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign accept = (state == GRANT) && req[gidx] && !w_full;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gidx_nxt  = gidx;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt     = GRANT;
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          gidx_nxt      = pick;
          bcnt_nxt      = '0;
        end
      end
      GRANT: begin
        if (accept)
          bcnt_nxt = bcnt + BCW'(1);
        // A dropped request abandons the grant even with no word accepted.
        if ((accept && bcnt == BCNT_LAST) || !req[gidx]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          last_nxt  = gidx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      last  <= LAST_RST;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  assign ack         = gnt & req & {NREQ{~w_full}};
  assign fifo_w_en   = |(gnt & req);
  assign fifo_w_data = (state == GRANT) ? req_data[int'(gidx)*WIDTH +: WIDTH] : '0;

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && v != 16'hFFFF)
      return v + 16'd1;
    return v;
  endfunction

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, (state == GRANT) && req[gidx] && w_full);
      word_cnt  <= sat_inc(word_cnt, |ack);
    end
  end
`else
  assign stall_cnt = '0;
  assign word_cnt  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester word queues drive req, expected
// (requester, word) pairs are popped and compared on every ack.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            w_clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic            w_full = 1'b0;
  logic [NREQ-1:0] gnt, ack;
  logic [W-1:0]    fifo_w_data;
  logic            fifo_w_en;
  logic [15:0]     stall_cnt, word_cnt;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(NREQ), .BURST_MAX(4)) dut (
    .w_clk(w_clk), .reset(reset), .req(req), .req_data(req_data), .w_full(w_full),
    .gnt(gnt), .ack(ack), .fifo_w_data(fifo_w_data), .fifo_w_en(fifo_w_en),
    .stall_cnt(stall_cnt), .word_cnt(word_cnt)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [7:0]  rq[NREQ][$];
  logic        wf[64];
  logic [63:0] ack_tr;
  logic [3:0]  gnt_tr[64];
  logic [3:0]  acked;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_stall, exp_word;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_word(input int r, input logic [7:0] d);
    rq[r].push_back(d);
  endtask

  task automatic exp_word_q(input int r, input logic [7:0] d);
    sb_t e;
    e.idx  = r;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rq[i].size() != 0);
      req_data[i*W +: W] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    sb.delete();
    for (int c = 0; c < 64; c++) wf[c] = 1'b0;
  endtask

  // Entered just after a rising edge; runs n cycles, checking acks at the falling edge.
  task automatic run(input int n);
    ack_tr = '0;
    for (int c = 0; c < n; c++) begin
      w_full = wf[c];
      drive_reqs();
      @(negedge w_clk);
      gnt_tr[c] = gnt;
      ack_tr[c] = |ack;
      acked     = ack;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if (sb.size() == 0) begin
            chk_eq("unexpected_ack", 64'(i), 64'hFF);
          end else begin
            sb_t e;
            e = sb.pop_front();
            chk_eq("ack_requester", 64'(i), 64'(e.idx));
            chk_eq("ack_data", 64'(fifo_w_data), 64'(e.data));
            chk_eq("ack_w_en", 64'(fifo_w_en), 64'd1);
          end
        end
      end
      @(posedge w_clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (acked[i]) void'(rq[i].pop_front());
    end
    w_full = 1'b0;
    drive_reqs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    w_full = 1'b0;
    clear_all();
    @(posedge w_clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_eq("rst_gnt", 64'(gnt), 64'd0);
    chk_eq("rst_ack", 64'(ack), 64'd0);
    chk_eq("rst_w_en", 64'(fifo_w_en), 64'd0);
    chk_eq("rst_w_data", 64'(fifo_w_data), 64'd0);
    chk_eq("rst_stall", 64'(stall_cnt), 64'd0);
    chk_eq("rst_word", 64'(word_cnt), 64'd0);

    // Single requester, 6 words: burst of 4, idle gap, burst of 2
    for (int k = 0; k < 6; k++) begin
      add_word(0, 8'(8'hA0 + k));
      exp_word_q(0, 8'(8'hA0 + k));
    end
    run(10);
    chk_eq("s1_gnt_first", 64'(gnt_tr[1]), 64'b0001);
    chk_eq("s1_ack_timing", 64'(ack_tr[9:0]), 64'h0DE);
    chk_eq("s1_drain", 64'(sb.size()), 64'd0);

    // All four requesting: rotation 0,1,2,3,0 with 4-word bursts
    do_reset();
    for (int k = 0; k < 8; k++) add_word(0, 8'(8'h00 + k));
    for (int r = 1; r < NREQ; r++)
      for (int k = 0; k < 4; k++) add_word(r, 8'(r*16 + k));
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++)
        exp_word_q(b % 4, (b == 4) ? 8'(4 + k) : 8'((b % 4)*16 + k));
    run(26);
    for (int b = 0; b < 5; b++)
      chk_eq("s2_gnt_order", 64'(gnt_tr[1 + 5*b]), 64'(4'b0001 << (b % 4)));
    begin
      logic [63:0] et;
      et = '0;
      for (int c = 0; c < 26; c++) et[c] = (c % 5 != 0);
      chk_eq("s2_ack_timing", ack_tr & 64'h3FF_FFFF, et);
    end
    chk_eq("s2_drain", 64'(sb.size()), 64'd0);

    // Requester 2 stalled by w_full for 5 cycles after its 2nd ack
    for (int k = 0; k < 4; k++) begin
      add_word(2, 8'(8'hC0 + k));
      exp_word_q(2, 8'(8'hC0 + k));
    end
    for (int c = 3; c < 8; c++) wf[c] = 1'b1;
    run(11);
    for (int c = 0; c < 64; c++) wf[c] = 1'b0;
    chk_eq("s3_gnt_held", 64'(gnt_tr[3]), 64'b0100);
    chk_eq("s3_gnt_held_end", 64'(gnt_tr[7]), 64'b0100);
    chk_eq("s3_ack_timing", 64'(ack_tr[10:0]), 64'h306);
    chk_eq("s3_released", 64'(gnt_tr[10]), 64'd0);
    chk_eq("s3_drain", 64'(sb.size()), 64'd0);

    // Requester 1 abandons after one ack, then 0011 contends
    do_reset();
    add_word(1, 8'h51);
    exp_word_q(1, 8'h51);
    run(4);
    chk_eq("s4_ack_timing", 64'(ack_tr[3:0]), 64'b0010);
    chk_eq("s4_gnt_after_drop", 64'(gnt_tr[2]), 64'b0010);
    chk_eq("s4_released", 64'(gnt_tr[3]), 64'd0);
    for (int k = 0; k < 2; k++) begin
      add_word(0, 8'(8'h60 + k));
      add_word(1, 8'(8'h70 + k));
    end
    for (int k = 0; k < 2; k++) exp_word_q(0, 8'(8'h60 + k));
    for (int k = 0; k < 2; k++) exp_word_q(1, 8'(8'h70 + k));
    run(8);
    chk_eq("s4_gnt_r0", 64'(gnt_tr[1]), 64'b0001);
    chk_eq("s4_gnt_r1", 64'(gnt_tr[5]), 64'b0010);
    chk_eq("s4_drain", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a burst
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add_word(2, 8'(8'hD0 + k));
      exp_word_q(2, 8'(8'hD0 + k));
    end
    run(3);
    chk_eq("s5_ack_pre_reset", 64'(ack), 64'b0100);
    #1;
    reset = 1'b0;
    #1;
    chk_eq("s5_gnt_async", 64'(gnt), 64'd0);
    chk_eq("s5_ack_async", 64'(ack), 64'd0);
    chk_eq("s5_w_en_async", 64'(fifo_w_en), 64'd0);
    chk_eq("s5_w_data_async", 64'(fifo_w_data), 64'd0);
    chk_eq("s5_word_async", 64'(word_cnt), 64'd0);
    clear_all();
    req = '0;
    #1;
    reset = 1'b1;
    @(posedge w_clk);
    #1;
    add_word(3, 8'hE3);
    exp_word_q(3, 8'hE3);
    run(3);
    chk_eq("s5_gnt_r3", 64'(gnt_tr[1]), 64'b1000);
    chk_eq("s5_ack_r3", 64'(ack_tr[2:0]), 64'b010);
    chk_eq("s5_drain", 64'(sb.size()), 64'd0);

    // Statistics: 10 accepted words, 3 stall cycles
    do_reset();
    for (int k = 0; k < 10; k++) begin
      add_word(0, 8'(8'h10 + k));
      exp_word_q(0, 8'(8'h10 + k));
    end
    for (int c = 2; c < 5; c++) wf[c] = 1'b1;
    run(17);
    chk_eq("s6_drain", 64'(sb.size()), 64'd0);
`ifdef FIFO_ARB_STATS_EN
    exp_word  = 10;
    exp_stall = 3;
`else
    exp_word  = 0;
    exp_stall = 0;
`endif
    chk_eq("s6_word_cnt", 64'(word_cnt), 64'(exp_word));
    chk_eq("s6_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port among `NREQ` requesters in the `w_clk` domain using round-robin, burst-limited grants. It drives the FIFO's `w_data`/`source_w_en` inputs and honours `w_full`, so no word is dropped and no requester is starved.

## Interface
Parameters:
- `WIDTH`, 8: data word width; must match the FIFO `WIDTH`.
- `NREQ`, 4: number of requesters, 2..8.
- `BURST_MAX`, 4: maximum words accepted per grant, 1..16.

Ports:
- `w_clk` input 1: write-domain clock. Everything is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input `NREQ`: per-requester write request. Held high while the requester has a word on its data slice.
- `req_data` input `NREQ*WIDTH`: requester data. Requester i uses bits `[i*WIDTH +: WIDTH]`.
- `w_full` input 1: full flag from the FIFO.
- `gnt` output `NREQ`: one-hot registered grant, all-zero when idle.
- `ack` output `NREQ`: combinational. `ack[i] = gnt[i] & req[i] & ~w_full` means the word was accepted this cycle.
- `fifo_w_data` output `WIDTH`: combinational mux of the granted slice; 0 when idle.
- `fifo_w_en` output 1: combinational, `|(gnt & req)`. The FIFO applies its own `~w_full` mask.
- `stall_cnt` output 16: stall-cycle counter (see Configuration).
- `word_cnt` output 16: accepted-word counter (see Configuration).

## Operation
- The FSM has two states, IDLE and GRANT. Held registers:
  - `gidx` is the granted index.
  - `last` is the last granted index.
  - `bcnt` is the count of words accepted in the current burst, `$clog2(BURST_MAX)+1` bits.
- IDLE with `req == 0`: remain in IDLE, `gnt = 0`.
- IDLE with any `req` bit set:
  - Select the first set bit scanning `last+1, last+2, …`, wrapping modulo `NREQ`.
  - Load `gnt` one-hot and `gidx`, clear `bcnt`, go to GRANT.
- GRANT, word accepted (`req[gidx] & ~w_full`): increment `bcnt`.
- GRANT, release condition: either of the following returns the FSM to IDLE with `gnt = 0` and `last = gidx`.
  - A word is accepted while `bcnt == BURST_MAX-1`.
  - `req[gidx]` is low, whether or not any word was accepted.
- GRANT with `w_full` high and `req[gidx]` high: hold the grant. `bcnt` is unchanged, no ack, and the requester keeps its data stable.
- Requesters must not drop `req[i]` while `gnt[i]` is high and `ack[i]` is low, except to abandon the grant, which releases it.
- Non-granted requests are ignored until the next IDLE arbitration.
- After reset, `last = NREQ-1`, so requester 0 wins the first contention.

## Timing
- Reset values:
  - State IDLE, `gnt = 0`, `gidx = 0`, `last = NREQ-1`, `bcnt = 0`.
  - `ack = 0`, `fifo_w_en = 0`, `fifo_w_data = 0`.
  - `stall_cnt = 0`, `word_cnt = 0`.
- Request-to-grant: `req` high before edge k gives `gnt` valid after edge k. The first ack is possible in the cycle following edge k.
- Release takes effect at the edge of the last ack. There is one mandatory IDLE cycle, then the next grant at the following edge.
- Peak throughput is `BURST_MAX` words per `BURST_MAX+1` cycles.
- `ack`, `fifo_w_en` and `fifo_w_data` have zero latency from `req` and `w_full`; there is no combinational path from `gnt` logic back into `req`.
- Reset asserted mid-burst: all outputs go to their reset values immediately (asynchronous). In-flight unacked words are not written.
- `w_full` toggling inside a burst only delays the acks; the burst length still counts accepted words only.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - `stall_cnt` increments in each GRANT cycle with `req[gidx] & w_full`.
  - `word_cnt` increments on each ack.
  - Both are 16-bit, saturate at `16'hFFFF`, and clear on reset.
- `FIFO_ARB_STATS_EN` not defined: both ports exist but are tied to 0, and no counter logic is synthesised.

## Test plan
- Reset, then `req = 4'b0001` with data 8'hA0..A5 and `w_full = 0` → `gnt = 0001` after one edge. Acks come in 4 consecutive cycles (A0..A3), then 1 idle cycle, then a new grant and A4, A5.
- `req = 4'b1111` held, `w_full = 0`, with `BURST_MAX = 4` → grants in order 0, 1, 2, 3, 0. Each burst is 4 acks separated by 1 idle cycle.
- Requester 2 is granted, `w_full` is forced high for 5 cycles after its 2nd ack → `gnt = 0100` held and no acks during that time. Then 2 more acks and release. `bcnt` ends at 4.
- Requester 1 is granted and drops `req` after 1 ack → release the next edge, `last = 1`. With `req = 4'b0011` the next grant goes to requester 0 only if requester 2 and requester 3 are idle.
- Mid-burst async `reset` low → `gnt`, `ack` and `fifo_w_en` are 0 immediately. After release, `req = 4'b1000` is granted to requester 3 within one edge.
- With `FIFO_ARB_STATS_EN`: 10 acks and 3 stall cycles → `word_cnt = 10`, `stall_cnt = 3`. Without the macro, both read 0.
